apb_burst_master: RTL and testbench
===================================

// Module: apb_burst_master
// PURPOSE
//  Command-driven APB3 master that turns one burst command into N back-to-back single APB
//  transfers on incrementing addresses. Write data comes from a valid/ready stream; read data
//  goes out on a valid/ready stream. Sits directly upstream of the APB SRAM slave.
//  Used by the loader/scrubber paths to fill or dump on-chip SRAM without a CPU.
// PARAMETERS
//  APB_DWIDTH   32  data width: 32, 24, 16 or 8; must match the downstream slave
//  ADDR_SCHEME   0  0: byte addressing, PADDR step 4 per beat; 1: location addressing, step 1
// PORTS
//  PCLK         in   1      clock
//  PRESETN      in   1      asynchronous active-low reset
//  cmd_valid    in   1      burst command valid
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_write    in   1      1 = write burst, 0 = read burst
//  cmd_addr     in   17     start PADDR
//  cmd_len      in   13     beats minus one (0 => 1 beat, 8191 => 8192 beats)
//  wdata_valid  in   1      write stream valid
//  wdata_ready  out  1      write stream ready
//  wdata        in   DW     write stream data
//  rdata_valid  out  1      read stream valid
//  rdata_ready  in   1      read stream ready
//  rdata        out  DW     read stream data
//  busy         out  1      high from command accept until done
//  done         out  1      one-cycle pulse when the last beat completes
//  err          out  1      valid with done: OR of PSLVERR over all beats of the burst
//  PSEL, PENABLE, PWRITE  out  1   APB control
//  PADDR        out  17     APB address
//  PWDATA       out  DW     APB write data
//  PRDATA       in   DW     APB read data
//  PREADY       in   1      APB ready (wait states allowed)
//  PSLVERR      in   1      APB error
// BEHAVIOUR
//  Reset: every output is 0; FSM returns to IDLE; no pending beat survives reset.
//  FSM states: IDLE, WDATA, SETUP, ACCESS, RDRAIN, DONE.
//  IDLE:   cmd_ready=1. On cmd_valid: latch addr, len, write; clear err accumulator; busy=1.
//          Next state is WDATA for a write, SETUP for a read.
//  WDATA:  wdata_ready=1. On wdata_valid: PWDATA<=wdata, then SETUP. Stall indefinitely otherwise.
//  SETUP:  PSEL=1, PENABLE=0, PADDR/PWRITE stable. Always exactly 1 cycle; next state ACCESS.
//  ACCESS: PSEL=1, PENABLE=1. Hold while PREADY=0. When PREADY=1:
//          - err_acc |= PSLVERR
//          - for a read, rdata<=PRDATA, rdata_valid=1, next state RDRAIN
//          - for a write, next state is DONE if this was the last beat, else WDATA
//  RDRAIN: PSEL=0. Hold rdata/rdata_valid until rdata_ready. Then next state is DONE if this
//          was the last beat, else SETUP.
//  DONE:   done=1 and err=err_acc for one cycle; busy drops in this same cycle; next state IDLE.
//  PADDR, PWRITE and PWDATA change only when entering SETUP. PSEL=0 in IDLE, WDATA, RDRAIN, DONE.
//  Address: PADDR += (ADDR_SCHEME ? 1 : 4) after each completed beat; modulo 2^17 (wraps).
//  Beat counter is 13 bits and decrements per beat; the last beat is when counter==0.
//  PSLVERR does not abort the burst; the remaining beats still issue.
//  Minimum beat cost with no stalls: write 3 cycles, read 3 cycles (SETUP, ACCESS, RDRAIN).
//  APB_DWIDTH<32: only low DW bits are used; PADDR upper bits come from the address arithmetic.
//  cmd_ready=0 whenever busy; there is no command queuing.
// STRUCTURE
//  Shared package: FSM state encoding (3-bit localparams), the addr_step(ADDR_SCHEME) function,
//  and the APB address width constant (17).
//  Single module with no sub-module: a one-entry read holding register plus the FSM is
//  small enough to stay inline.
// TESTING
//  1. Write cmd addr=0x0000, len=3, ADDR_SCHEME=0, wdata 0x11,0x22,0x33,0x44, PREADY=1
//     -> PADDR 0x0,0x4,0x8,0xC; done after the 4th ACCESS; err=0.
//  2. Read cmd addr=0x0004, len=1, rdata_ready held low 5 cycles
//     -> rdata=0x22 held stable; no 2nd SETUP until it is accepted; then rdata=0x33.
//  3. Slave inserts 2 PREADY=0 cycles on beat 2 with PSLVERR=1
//     -> ACCESS lasts 3 cycles; all beats still complete; done with err=1.
//  4. ADDR_SCHEME=1, addr=0x1FFFF, len=1 -> PADDR 0x1FFFF then 0x00000 (wrap).
//  5. PRESETN low during ACCESS of beat 1 of 4
//     -> PSEL/PENABLE/busy=0 immediately; cmd_ready=1 after reset release; a new cmd runs cleanly.
//  6. Write with wdata_valid gapped (1 of every 3 cycles)
//     -> PSEL stays low while in WDATA; no APB transfer ever issues without captured data.

Source files
------------

// File: rtl/apb_burst_master_pkg.sv
// rtl/apb_burst_master_pkg.sv - shared constants, state encoding and address step for apb_burst_master
package apb_burst_master_pkg;

  localparam int APB_AWIDTH = 17;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_RDRAIN = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_WDATA  = ST_WDATA,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_RDRAIN = ST_RDRAIN,
    S_DONE   = ST_DONE
  } state_t;

  // Byte-addressed slaves advance one 32-bit word per beat; location-addressed ones advance by 1.
  function automatic logic [APB_AWIDTH-1:0] addr_step(input int scheme);
    return (scheme != 0) ? 17'd1 : 17'd4;
  endfunction

endpackage

// File: rtl/apb_burst_master.sv
// rtl/apb_burst_master.sv - command-driven APB3 burst master with write/read valid/ready streams
module apb_burst_master
  import apb_burst_master_pkg::*;
#(
  parameter int APB_DWIDTH  = 32,
  parameter int ADDR_SCHEME = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [16:0]           cmd_addr,
  input  logic [12:0]           cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [APB_DWIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [APB_DWIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [16:0]           PADDR,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_t                  r_state;
  logic [APB_AWIDTH-1:0]   r_addr;
  logic [12:0]             r_cnt;
  logic                    r_write;
  logic                    r_err_acc;

  logic                    w_last;
  logic [APB_AWIDTH-1:0]   w_step;

  assign w_last = (r_cnt == 13'd0);
  assign w_step = addr_step(ADDR_SCHEME);

  // r_addr always holds the address of the next beat; PADDR only copies it on entry to SETUP.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_err_acc   <= 1'b0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            r_addr    <= cmd_addr;
            r_cnt     <= cmd_len;
            r_write   <= cmd_write;
            r_err_acc <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              wdata_ready <= 1'b1;
              r_state     <= S_WDATA;
            end else begin
              PSEL    <= 1'b1;
              PADDR   <= cmd_addr;
              PWRITE  <= 1'b0;
              r_state <= S_SETUP;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WDATA: begin
          if (wdata_valid) begin
            wdata_ready <= 1'b0;
            PWDATA      <= wdata;
            PSEL        <= 1'b1;
            PADDR       <= r_addr;
            PWRITE      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            r_addr    <= r_addr + w_step;
            r_err_acc <= r_err_acc | PSLVERR;
            if (!r_write) begin
              rdata       <= PRDATA;
              rdata_valid <= 1'b1;
              r_state     <= S_RDRAIN;
            end else if (w_last) begin
              done    <= 1'b1;
              err     <= r_err_acc | PSLVERR;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt       <= r_cnt - 13'd1;
              wdata_ready <= 1'b1;
              r_state     <= S_WDATA;
            end
          end
        end
        S_RDRAIN: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (w_last) begin
              done    <= 1'b1;
              err     <= r_err_acc;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt - 13'd1;
              PSEL    <= 1'b1;
              PADDR   <= r_addr;
              PWRITE  <= 1'b0;
              r_state <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_burst_master.sv
// tb/tb_apb_burst_master.sv - scoreboard bench for apb_burst_master with an APB SRAM slave model
module tb_apb_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [12:0] cmd_len = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid, rdata_ready = 1'b1;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic        psel, penable, pwrite;
  logic [16:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  logic        c1_cmd_valid = 1'b0, c1_cmd_ready;
  logic [16:0] c1_cmd_addr = '0;
  logic [12:0] c1_cmd_len = '0;
  logic        c1_wdata_ready, c1_rdata_valid;
  logic [31:0] c1_rdata, c1_pwdata;
  logic        c1_busy, c1_done, c1_err, c1_psel, c1_penable, c1_pwrite;
  logic [16:0] c1_paddr;

  apb_burst_master #(.APB_DWIDTH(32), .ADDR_SCHEME(0)) u_dut (
    .PCLK(clk), .PRESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done), .err(err),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_burst_master #(.APB_DWIDTH(32), .ADDR_SCHEME(1)) u_dut1 (
    .PCLK(clk), .PRESETN(rst_n),
    .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready), .cmd_write(1'b0),
    .cmd_addr(c1_cmd_addr), .cmd_len(c1_cmd_len),
    .wdata_valid(1'b0), .wdata_ready(c1_wdata_ready), .wdata(32'h0),
    .rdata_valid(c1_rdata_valid), .rdata_ready(1'b1), .rdata(c1_rdata),
    .busy(c1_busy), .done(c1_done), .err(c1_err),
    .PSEL(c1_psel), .PENABLE(c1_penable), .PWRITE(c1_pwrite), .PADDR(c1_paddr),
    .PWDATA(c1_pwdata), .PRDATA(32'h0), .PREADY(1'b1), .PSLVERR(1'b0)
  );

  // APB SRAM slave with an optional stall of stall_len cycles on transfer number stall_at.
  logic [31:0] mem [0:255];
  int          xfer_num = 0;
  int          ws_cnt = 0;
  int          stall_at = -1;
  int          stall_len = 0;
  logic        err_en = 1'b0;

  assign pready  = (ws_cnt == 0);
  assign prdata  = mem[paddr[9:2]];
  assign pslverr = psel && penable && pready && err_en && (xfer_num == stall_at);

  always @(posedge clk) begin
    if (psel && !penable && xfer_num == stall_at) ws_cnt <= stall_len;
    else if (psel && penable && ws_cnt != 0)      ws_cnt <= ws_cnt - 1;
    else if (!psel)                               ws_cnt <= 0;
    if (psel && penable && pready) begin
      xfer_num <= xfer_num + 1;
      if (pwrite) mem[paddr[9:2]] <= pwdata;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard queues: stimulus pushes, monitors pop.
  logic [49:0] exp_apb [$];
  logic [31:0] exp_rd [$];
  logic        exp_err [$];
  logic [31:0] wq [$];
  int          done_cnt = 0;
  int          acc_cycles = 0;
  logic        chk_wdata = 1'b0;

  always @(negedge clk) begin
    if (rst_n && psel && penable && pready) begin
      if (exp_apb.size() == 0) timeout("apb_unexpected_transfer");
      else check("apb_transfer", {14'h0, pwrite, paddr, (pwrite ? pwdata : 32'h0)},
                 {14'h0, exp_apb.pop_front()});
    end
    if (rst_n && psel && penable) acc_cycles++;
    if (rst_n && rdata_valid && rdata_ready) begin
      if (exp_rd.size() == 0) timeout("rdata_unexpected");
      else check("rdata_beat", {32'h0, rdata}, {32'h0, exp_rd.pop_front()});
    end
    if (rst_n && done) begin
      done_cnt++;
      if (exp_err.size() == 0) timeout("done_unexpected");
      else check("done_err", {63'h0, err}, {63'h0, exp_err.pop_front()});
    end
    if (rst_n && chk_wdata && wdata_ready) check("psel_low_in_wdata", {63'h0, psel}, 64'h0);
  end

  task automatic plan_write(input logic [16:0] a, input int n, input logic [31:0] first,
                            input logic [31:0] inc, input logic e);
    for (int i = 0; i < n; i++) begin
      wq.push_back(first + inc * i);
      exp_apb.push_back({1'b1, a + 17'(4 * i), first + inc * i});
    end
    exp_err.push_back(e);
  endtask

  task automatic plan_read(input logic [16:0] a, input int n, input logic [31:0] first,
                           input logic [31:0] inc, input logic e);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(first + inc * i);
      exp_apb.push_back({1'b0, a + 17'(4 * i), 32'h0});
    end
    exp_err.push_back(e);
  endtask

  task automatic send_cmd(input logic w, input logic [16:0] a, input logic [12:0] l);
    logic ok;
    ok = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) timeout("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int period);
    logic got;
    int   k;
    while (wq.size() > 0) begin
      wdata = wq[0];
      got = 1'b0;
      k = 0;
      while (!got && k < 60) begin
        wdata_valid = (k % period == 0);
        @(negedge clk);
        got = wdata_valid && wdata_ready;
        @(posedge clk); #1;
        k++;
      end
      wdata_valid = 1'b0;
      if (!got) begin
        timeout("wdata_accept");
        wq.delete();
      end else begin
        void'(wq.pop_front());
      end
    end
  endtask

  task automatic wait_done(input int prev);
    int i;
    i = 0;
    while (done_cnt == prev && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == prev) timeout("burst_done");
    @(posedge clk); #1;
  endtask

  initial begin
    int          d0, a0, n;
    logic        got, seen;
    logic [16:0] seen_addr [0:3];
    logic        seen_err;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {cmd_ready, wdata_ready, rdata_valid, busy, done, err, psel, penable, pwrite, paddr, pwdata},
          64'h0);
    check("reset_rdata", {32'h0, rdata}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", {63'h0, cmd_ready}, 64'h1);
    @(posedge clk); #1;

    // Write burst: 4 beats at 0x0..0xC with 0x11..0x44.
    d0 = done_cnt;
    plan_write(17'h0, 4, 32'h11, 32'h11, 1'b0);
    send_cmd(1'b1, 17'h0, 13'd3);
    check("busy_after_accept", {62'h0, busy, cmd_ready}, 64'h2);
    feed(1);
    wait_done(d0);
    check("idle_after_done", {62'h0, busy, psel}, 64'h0);

    // Read 2 beats from 0x4 with the consumer stalled for 5 cycles.
    d0 = done_cnt;
    rdata_ready = 1'b0;
    plan_read(17'h4, 2, 32'h22, 32'h11, 1'b0);
    send_cmd(1'b0, 17'h4, 13'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdata_valid;
    end
    if (!got) timeout("rdata_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rdata_held", {31'h0, rdata_valid, rdata}, {31'h0, 1'b1, 32'h22});
      check("no_setup_while_stalled", {63'h0, psel}, 64'h0);
    end
    @(posedge clk); #1;
    rdata_ready = 1'b1;
    wait_done(d0);

    // Beat 2 of a write burst takes 2 wait states and raises PSLVERR.
    d0 = done_cnt;
    a0 = acc_cycles;
    stall_at = xfer_num + 1;
    stall_len = 2;
    err_en = 1'b1;
    plan_write(17'h10, 4, 32'hA1, 32'h1, 1'b1);
    send_cmd(1'b1, 17'h10, 13'd3);
    feed(1);
    wait_done(d0);
    check("access_cycles_with_wait", 64'(acc_cycles - a0), 64'd6);
    err_en = 1'b0;
    stall_at = -1;

    // Location addressing wraps from 0x1FFFF to 0x00000.
    c1_cmd_addr = 17'h1FFFF;
    c1_cmd_len = 13'd1;
    c1_cmd_valid = 1'b1;
    @(negedge clk);
    check("dut1_cmd_ready", {63'h0, c1_cmd_ready}, 64'h1);
    @(posedge clk); #1;
    c1_cmd_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    seen_err = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (c1_psel && !c1_penable && n < 4) begin
        seen_addr[n] = c1_paddr;
        n++;
      end
      if (c1_done) begin
        seen = 1'b1;
        seen_err = c1_err;
      end
    end
    if (!seen) timeout("dut1_done");
    check("wrap_setup_count", 64'(n), 64'd2);
    check("wrap_addr0", {47'h0, seen_addr[0]}, {47'h0, 17'h1FFFF});
    check("wrap_addr1", {47'h0, seen_addr[1]}, 64'h0);
    check("wrap_err", {63'h0, seen_err}, 64'h0);
    @(posedge clk); #1;

    // Reset asserted in the middle of a stalled ACCESS of beat 1 of 4.
    stall_at = xfer_num;
    stall_len = 10;
    send_cmd(1'b0, 17'h0, 13'd3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = psel && penable;
    end
    if (!got) timeout("reach_access");
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", {61'h0, psel, penable, busy}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_at = -1;
    @(negedge clk);
    check("cmd_ready_after_midburst_reset", {62'h0, cmd_ready, busy}, 64'h2);
    @(posedge clk); #1;
    d0 = done_cnt;
    plan_read(17'h0, 1, 32'h11, 32'h0, 1'b0);
    send_cmd(1'b0, 17'h0, 13'd0);
    wait_done(d0);

    // Write stream valid only one cycle in three; then read the data back.
    d0 = done_cnt;
    chk_wdata = 1'b1;
    plan_write(17'h20, 3, 32'h5A, 32'h1, 1'b0);
    send_cmd(1'b1, 17'h20, 13'd2);
    feed(3);
    wait_done(d0);
    chk_wdata = 1'b0;
    d0 = done_cnt;
    plan_read(17'h20, 3, 32'h5A, 32'h1, 1'b0);
    send_cmd(1'b0, 17'h20, 13'd2);
    wait_done(d0);

    repeat (3) @(negedge clk);
    check("apb_queue_drained", 64'(exp_apb.size()), 64'd0);
    check("rdata_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("done_queue_drained", 64'(exp_err.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
